// File: rtl/sram_pkg.sv
// sram_pkg: default SRAM widths plus FSM and owner encodings shared by the arbiter files
package sram_pkg;
    localparam int SRAM_ADDR_W = 19;
    localparam int SRAM_DATA_W = 16;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;
    typedef enum logic {OWN_A, OWN_B} owner_t;
endpackage

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: two-way round-robin grant; a tie goes to whichever side was not granted last
module sram_rr_arbiter import sram_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);
    owner_t last_grant;
    always_comb begin
        a_gnt = en && a_req && (!b_req || last_grant == OWN_B);
        b_gnt = en && b_req && (!a_req || last_grant == OWN_A);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) last_grant <= OWN_B;
        else if (a_gnt) last_grant <= OWN_A;
        else if (b_gnt) last_grant <= OWN_B;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between requesters A and B and sequences its strobes
module sram_arbiter import sram_pkg::*; #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [1:0]        a_be,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [1:0]        b_be,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_dat_o,
    output logic              ram_dat_oe,
    input  logic [DATA_W-1:0] ram_dat_i,
    output logic              ram_cs_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_lb_n,
    output logic              ram_ub_n
);
    state_t state, state_n;
    owner_t owner, nx_owner;
    logic [3:0] cnt;
    logic req_we, nx_we, gnt, last_acc, active_n;
    logic [1:0] req_be, nx_be;
    logic [ADDR_W-1:0] nx_adr;
    logic [DATA_W-1:0] nx_dat;

    sram_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state == IDLE),
        .a_req (a_valid),
        .b_req (b_valid),
        .a_gnt (a_ready),
        .b_gnt (b_ready)
    );

    assign gnt      = a_ready || b_ready;
    assign busy     = state != IDLE;
    assign last_acc = state == ACCESS && cnt == 4'd0;

    // Pins are registered, so everything is computed for the state being entered.
    always_comb begin
        state_n  = state == IDLE   ? (gnt ? SETUP : IDLE) :
                   state == SETUP  ? ACCESS :
                   state == ACCESS ? (last_acc ? RECOVER : ACCESS) : IDLE;
        nx_we    = a_ready ? a_we    : b_ready ? b_we    : req_we;
        nx_be    = a_ready ? a_be    : b_ready ? b_be    : req_be;
        nx_adr   = a_ready ? a_addr  : b_ready ? b_addr  : ram_adr;
        nx_dat   = a_ready ? a_wdata : b_ready ? b_wdata : ram_dat_o;
        nx_owner = a_ready ? OWN_A   : b_ready ? OWN_B   : owner;
        active_n = state_n == SETUP || state_n == ACCESS;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_A;
            cnt        <= 4'd0;
            req_we     <= 1'b0;
            req_be     <= 2'b00;
            ram_adr    <= '0;
            ram_dat_o  <= '0;
            ram_dat_oe <= 1'b0;
            ram_cs_n   <= 1'b1;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            ram_lb_n   <= 1'b1;
            ram_ub_n   <= 1'b1;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            state      <= state_n;
            owner      <= nx_owner;
            cnt        <= state == ACCESS ? cnt - 4'd1 : 4'(WAIT_CYCLES - 1);
            req_we     <= nx_we;
            req_be     <= nx_be;
            ram_adr    <= nx_adr;
            ram_dat_o  <= nx_dat;
            ram_dat_oe <= state_n != IDLE && nx_we;
            ram_cs_n   <= !active_n;
            ram_oe_n   <= !(active_n && !nx_we);
            ram_we_n   <= !(state_n == ACCESS && nx_we);
            ram_lb_n   <= !(active_n && nx_be[0]);
            ram_ub_n   <= !(active_n && nx_be[1]);
            a_rvalid   <= last_acc && !req_we && owner == OWN_A;
            b_rvalid   <= last_acc && !req_we && owner == OWN_B;
            if (last_acc && !req_we && owner == OWN_A) a_rdata <= ram_dat_i;
            if (last_acc && !req_we && owner == OWN_B) b_rdata <= ram_dat_i;
        end
endmodule
